// File: rtl/std_countones_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : std_countones_acc_if
// Brief    : Beat-in / result-out handshake bundle for std_countones_acc.
// Revision : 1.0 - initial release
// ============================================================================
interface std_countones_acc_if #(
    parameter int W  = 32,
    parameter int CW = 16
);
    logic          i_valid;
    logic          o_ready;
    logic [W-1:0]  i_data;
    logic          i_last;
    logic          i_mode;
    logic          o_valid;
    logic          i_ready;
    logic [CW-1:0] o_count;
    logic [CW-1:0] o_beats;
    logic          o_sat;

    // The accumulator sits on the slave side.
    modport slave (
        input  i_valid, i_data, i_last, i_mode, i_ready,
        output o_ready, o_valid, o_count, o_beats, o_sat
    );

    modport master (
        output i_valid, i_data, i_last, i_mode, i_ready,
        input  o_ready, o_valid, o_count, o_beats, o_sat
    );
endinterface
`default_nettype wire

// File: rtl/std_countones_acc.sv
`default_nettype none
// ============================================================================
// Module   : std_countones_acc
// Brief    : Per-packet saturating accumulator of set/clear bit counts.
// Revision : 1.0 - initial release
// ============================================================================
module std_countones_acc #(
    parameter int W  = 32,
    parameter int CW = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    std_countones_acc_if.slave  bus
);
    localparam int C_MIN_CW = (W > 1) ? $clog2(W) + 1 : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    generate
        if (CW < C_MIN_CW) begin : g_bad_cw
            $error("std_countones_acc: CW too small for W");
        end
    endgenerate

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] acc_q, acc_d;
    logic [CW-1:0] beats_q, beats_d;
    logic          sat_q, sat_d;
    logic [CW-1:0] count_out_q, count_out_d;
    logic [CW-1:0] beats_out_q, beats_out_d;
    logic          sat_out_q, sat_out_d;

    logic          w_accept;
    logic [W-1:0]  w_bits;
    logic [CW-1:0] w_beat_cnt;
    logic          w_open;
    logic [CW:0]   w_sum;
    logic [CW:0]   w_bsum;
    logic [CW-1:0] w_total;
    logic [CW-1:0] w_beats_tot;
    logic          w_sat_new;

    assign bus.o_ready = (state_q != S_OUT) || bus.i_ready;
    assign bus.o_valid = (state_q == S_OUT);
    assign bus.o_count = count_out_q;
    assign bus.o_beats = beats_out_q;
    assign bus.o_sat   = sat_out_q;

    assign w_accept = bus.i_valid && bus.o_ready;
    // Zero counting reuses the popcount on the inverted beat.
    assign w_bits   = bus.i_mode ? ~bus.i_data : bus.i_data;

    always_comb begin
        w_beat_cnt = '0;
        for (int i = 0; i < W; i++) begin
            w_beat_cnt = w_beat_cnt + CW'(w_bits[i]);
        end
    end

    // Only an open packet carries history; IDLE/OUT start from zero.
    assign w_open      = (state_q == S_ACC);
    assign w_sum       = {1'b0, (w_open ? acc_q : '0)} + {1'b0, w_beat_cnt};
    assign w_bsum      = {1'b0, (w_open ? beats_q : '0)} + (CW+1)'(1);
    assign w_total     = w_sum[CW]  ? {CW{1'b1}} : w_sum[CW-1:0];
    assign w_beats_tot = w_bsum[CW] ? {CW{1'b1}} : w_bsum[CW-1:0];
    assign w_sat_new   = (w_open && sat_q) || w_sum[CW] || w_bsum[CW];

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        sat_d       = sat_q;
        count_out_d = count_out_q;
        beats_out_d = beats_out_q;
        sat_out_d   = sat_out_q;
        if (w_accept) begin
            acc_d   = w_total;
            beats_d = w_beats_tot;
            sat_d   = w_sat_new;
            if (bus.i_last) begin
                state_d     = S_OUT;
                count_out_d = w_total;
                beats_out_d = w_beats_tot;
                sat_out_d   = w_sat_new;
            end else begin
                state_d = S_ACC;
            end
        end else if (state_q == S_OUT && bus.i_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            beats_q     <= '0;
            sat_q       <= 1'b0;
            count_out_q <= '0;
            beats_out_q <= '0;
            sat_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            sat_q       <= sat_d;
            count_out_q <= count_out_d;
            beats_out_q <= beats_out_d;
            sat_out_q   <= sat_out_d;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_std_countones_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_std_countones_acc
// Brief    : Directed bench for std_countones_acc (CW=8 and CW=4 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_std_countones_acc;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    std_countones_acc_if #(.W(8), .CW(8)) bus8 ();
    std_countones_acc_if #(.W(8), .CW(4)) bus4 ();

    std_countones_acc #(.W(8), .CW(8)) u_dut8 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus8)
    );

    std_countones_acc #(.W(8), .CW(4)) u_dut4 (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic last, input logic mode);
        bus8.i_valid = v;  bus8.i_data = d;  bus8.i_last = last;  bus8.i_mode = mode;
        bus4.i_valid = v;  bus4.i_data = d;  bus4.i_last = last;  bus4.i_mode = mode;
        #1;
    endtask

    task automatic set_ready(input logic r);
        bus8.i_ready = r;
        bus4.i_ready = r;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        set_ready(1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);

        // Reset state
        tick();
        check("rst_valid", 32'(bus8.o_valid), 0);
        check("rst_count", 32'(bus8.o_count), 0);
        check("rst_beats", 32'(bus8.o_beats), 0);
        check("rst_sat",   32'(bus8.o_sat),   0);
        check("rst_ready", 32'(bus8.o_ready), 1);
        rst = 1'b0;

        // Single beat 0xA5
        drive(1'b1, 8'hA5, 1'b1, 1'b0);
        tick();
        check("a5_valid", 32'(bus8.o_valid), 1);
        check("a5_count", 32'(bus8.o_count), 4);
        check("a5_beats", 32'(bus8.o_beats), 1);
        check("a5_sat",   32'(bus8.o_sat),   0);

        // Three-beat packet, zero-bubble after previous result
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        tick();
        check("p3_valid_b1", 32'(bus8.o_valid), 0);
        drive(1'b1, 8'h0F, 1'b0, 1'b0);
        tick();
        check("p3_valid_b2", 32'(bus8.o_valid), 0);
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        tick();
        check("p3_valid", 32'(bus8.o_valid), 1);
        check("p3_count", 32'(bus8.o_count), 13);
        check("p3_beats", 32'(bus8.o_beats), 3);

        // Backpressure for 5 cycles with a beat offered
        set_ready(1'b0);
        drive(1'b1, 8'h03, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 32'(bus8.o_ready), 0);
            tick();
            check("bp_valid", 32'(bus8.o_valid), 1);
            check("bp_count", 32'(bus8.o_count), 13);
            check("bp_beats", 32'(bus8.o_beats), 3);
        end
        set_ready(1'b1);
        check("bp_ready_rel", 32'(bus8.o_ready), 1);
        tick();
        check("bp_next_valid", 32'(bus8.o_valid), 1);
        check("bp_next_count", 32'(bus8.o_count), 2);
        check("bp_next_beats", 32'(bus8.o_beats), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        check("idle_valid", 32'(bus8.o_valid), 0);
        check("idle_hold",  32'(bus8.o_count), 2);

        // Mode mix: zeros of 0x01 then ones of 0xF0
        drive(1'b1, 8'h01, 1'b0, 1'b1);
        tick();
        drive(1'b1, 8'hF0, 1'b1, 1'b0);
        tick();
        check("mix_count", 32'(bus8.o_count), 11);
        check("mix_beats", 32'(bus8.o_beats), 2);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        // Saturation on the CW=4 instance
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        tick();
        check("sat4_count", 32'(bus4.o_count), 15);
        check("sat4_sat",   32'(bus4.o_sat),   1);
        check("sat4_beats", 32'(bus4.o_beats), 2);
        check("sat8_count", 32'(bus8.o_count), 16);
        check("sat8_sat",   32'(bus8.o_sat),   0);
        drive(1'b1, 8'h01, 1'b1, 1'b0);
        tick();
        check("sat4_next_count", 32'(bus4.o_count), 1);
        check("sat4_next_sat",   32'(bus4.o_sat),   0);
        check("sat4_next_beats", 32'(bus4.o_beats), 1);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        // Reset mid-packet with a beat offered during reset
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        tick();
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, 8'hFF, 1'b1, 1'b0);
        check("mrst_ready", 32'(bus8.o_ready), 1);
        tick();
        check("mrst_valid", 32'(bus8.o_valid), 0);
        check("mrst_count", 32'(bus8.o_count), 0);
        rst = 1'b0;
        drive(1'b1, 8'h03, 1'b1, 1'b0);
        check("mrst_valid_pre", 32'(bus8.o_valid), 0);
        tick();
        check("mrst_res_valid", 32'(bus8.o_valid), 1);
        check("mrst_res_count", 32'(bus8.o_count), 2);
        check("mrst_res_beats", 32'(bus8.o_beats), 1);
        check("mrst_res_sat",   32'(bus8.o_sat),   0);
        check("mrst4_count",    32'(bus4.o_count), 2);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/std_countones_acc.md
STD_COUNTONES_ACC -- requirements
Module: std_countones_acc

Interface
REQ-001 SHALL have parameter W, default 32: data beat width in bits, W >= 1.
REQ-002 SHALL have parameter CW, default 16: count width in bits; elaboration SHALL fail if CW < ($clog2(W)+1 when W>1, else 1).
REQ-003 SHALL have port i_clk, input, 1: sole clock, all state on rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port i_valid, input, 1: input beat valid.
REQ-006 SHALL have port o_ready, output, 1: block accepts beat this cycle.
REQ-007 SHALL have port i_data, input, W: input beat.
REQ-008 SHALL have port i_last, input, 1: beat closes the current packet.
REQ-009 SHALL have port i_mode, input, 1: per-beat select; 0 = count ones, 1 = count zeros.
REQ-010 SHALL have port o_valid, output, 1: packet result valid.
REQ-011 SHALL have port i_ready, input, 1: downstream accepts result.
REQ-012 SHALL have port o_count, output, CW: saturated packet total of counted bits.
REQ-013 SHALL have port o_beats, output, CW: saturated number of beats in the packet.
REQ-014 SHALL have port o_sat, output, 1: o_count or o_beats saturated in this packet.

Function
REQ-015 SHALL implement states IDLE (no packet open), ACC (packet open), OUT (result held, o_valid=1).
REQ-016 SHALL drive o_ready = (state != OUT) || i_ready.
REQ-017 SHALL treat a beat as accepted when i_valid && o_ready; unaccepted beats SHALL leave all state unchanged.
REQ-018 SHALL compute per-beat count as the number of 1 bits in i_data (i_mode=0) or 0 bits (i_mode=1), range 0..W, combinationally.
REQ-019 SHALL set accumulator base to 0 when the beat is accepted in IDLE or OUT, else to the running total; new total = base + beat count.
REQ-020 SHALL clamp totals and beat counter at 2^CW-1; any clamp SHALL set a per-packet sticky saturation flag, cleared at packet start.
REQ-021 Transitions: IDLE/OUT + accepted beat with i_last=0 -> ACC; any state + accepted beat with i_last=1 -> OUT; ACC stays ACC without accepted last; OUT + i_ready with no accepted beat -> IDLE; OUT without i_ready holds.
REQ-022 On accepted last beat SHALL register o_count, o_beats, o_sat and assert o_valid the following cycle (latency 1 from last beat).
REQ-023 SHALL hold o_count, o_beats, o_sat stable while o_valid && !i_ready.
REQ-024 In OUT with i_ready=1 and a beat accepted the same cycle, SHALL complete the output handshake and start a fresh packet from that beat (zero bubble).
REQ-025 A single-beat packet (i_last on first beat) SHALL yield o_beats=1.
REQ-026 o_count/o_beats/o_sat SHALL be don't-care-free: they SHALL hold the last result when o_valid=0.

Reset
REQ-027 With i_rst=1 at a clock edge SHALL force state IDLE, o_valid=0, o_count=0, o_beats=0, o_sat=0, accumulators 0.
REQ-028 Reset mid-packet SHALL discard the partial packet; no residue SHALL appear in the next result.
REQ-029 While i_rst=1, o_ready SHALL still follow REQ-016 but no beat SHALL be taken into state.

Verification (W=8, CW=8 unless stated)
REQ-030 Single beat 0xA5, i_last=1, mode 0 -> next cycle o_valid=1, o_count=4, o_beats=1, o_sat=0.
REQ-031 Beats 0xFF, 0x0F, 0x01 (last on third) -> o_count=13, o_beats=3; o_valid low during first two beats.
REQ-032 Result pending with i_ready=0 for 5 cycles -> o_ready=0, o_count stable, offered beat not consumed; i_ready=1 with beat 0x03 last -> handshake done, next result o_count=2, no bubble.
REQ-033 W=8, CW=4: beats 0xFF, 0xFF last -> o_count=15, o_sat=1; following packet 0x01 last -> o_count=1, o_sat=0.
REQ-034 Mode mix: beat 0x01 mode 1, then 0xF0 mode 0 last -> o_count=11, o_beats=2.
REQ-035 Beats 0xFF, 0xFF then i_rst one cycle, then 0x03 last -> o_count=2, o_beats=1; o_valid=0 during and after reset until the result.
